// File: rtl/regfile_wseq_pkg.sv
// Shared types and default sizing for the register file write sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// Entry struct here carries the default widths; the top re-declares it when overridden.
package regfile_wseq_pkg;

    localparam int WSEQ_DATA_W     = 32;
    localparam int WSEQ_ADDR_W     = 5;
    localparam int WSEQ_NUM_REGS   = 32;
    localparam int WSEQ_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } wseq_state_t;

    typedef struct packed {
        logic [WSEQ_ADDR_W-1:0] addr;
        logic [WSEQ_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/regfile_wseq_fifo.sv
// Pending-write FIFO with an age-ordered view (index 0 = oldest) for hazard compares.
// Latency: push visible at head one cycle later. Backpressure: caller honours full/empty.
// Data view port exists only with REGFILE_WSEQ_FWD_EN.
module regfile_wseq_fifo
    import regfile_wseq_pkg::*;
#(
    parameter int  DEPTH   = WSEQ_FIFO_DEPTH,
    parameter int  ADDR_W  = WSEQ_ADDR_W,
    parameter type entry_t = wr_entry_t
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  entry_t            push_dat,
    input  logic              pop,
    output entry_t            head_dat,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] view_addr [DEPTH],
`ifdef REGFILE_WSEQ_FWD_EN
    output logic [$bits(entry_t)-ADDR_W-1:0] view_data [DEPTH],
`endif
    output logic [DEPTH-1:0]  view_vld
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

    for (genvar k = 0; k < DEPTH; k++) begin : g_view
        logic [PTR_W-1:0] idx;
        assign idx          = rd_ptr + PTR_W'(k);
        assign view_vld[k]  = (CNT_W'(k) < count);
        assign view_addr[k] = mem[idx].addr;
`ifdef REGFILE_WSEQ_FWD_EN
        assign view_data[k] = mem[idx].data;
`endif
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Register file write front end: zero-clears all registers after reset, then drains buffered writebacks.
// Latency: accept at edge N -> rf_we after edge N+1. Backpressure: in_ready low while FIFO full or clearing.
// REGFILE_WSEQ_FWD_EN adds q_data, the youngest pending data for q_addr.
module regfile_write_sequencer
    import regfile_wseq_pkg::*;
#(
    parameter int DATA_W     = WSEQ_DATA_W,
    parameter int ADDR_W     = WSEQ_ADDR_W,
    parameter int NUM_REGS   = WSEQ_NUM_REGS,
    parameter int FIFO_DEPTH = WSEQ_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] q_addr,
`ifdef REGFILE_WSEQ_FWD_EN
    output logic [DATA_W-1:0] q_data,
`endif
    output logic              q_hit
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    wseq_state_t        st;
    wseq_state_t        st_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               clr_last;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    entry_t             push_dat;
    entry_t             head_dat;
    logic [FIFO_DEPTH-1:0] view_vld;
    logic [ADDR_W-1:0]  view_addr [FIFO_DEPTH];
`ifdef REGFILE_WSEQ_FWD_EN
    logic [DATA_W-1:0]  view_data [FIFO_DEPTH];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_CLEAR;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (st == ST_CLEAR && clr_last) st_nxt = ST_RUN;
    end

    always_comb begin
        busy     = (st == ST_CLEAR);
        in_ready = (st == ST_RUN) && !fifo_full;
    end

    assign clr_last = (clr_cnt == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                clr_cnt <= '0;
        else if (st == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    // Writes to r0 are handshaken but never buffered.
    assign push          = in_valid && in_ready && (in_addr != '0);
    assign pop           = (st == ST_RUN) && !fifo_empty;
    assign push_dat.addr = in_addr;
    assign push_dat.data = in_data;

    regfile_wseq_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ADDR_W  (ADDR_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (pop),
        .head_dat  (head_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .view_addr (view_addr),
`ifdef REGFILE_WSEQ_FWD_EN
        .view_data (view_data),
`endif
        .view_vld  (view_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else if (st == ST_CLEAR) begin
            rf_we    <= 1'b1;
            rf_addr  <= clr_cnt;
            rf_wdata <= '0;
        end else if (pop) begin
            rf_we    <= 1'b1;
            rf_addr  <= head_dat.addr;
            rf_wdata <= head_dat.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scan oldest to newest so the youngest match is the one left standing.
    always_comb begin
        q_hit = 1'b0;
`ifdef REGFILE_WSEQ_FWD_EN
        q_data = '0;
`endif
        if (st == ST_RUN && q_addr != '0) begin
            if (rf_we && rf_addr == q_addr) begin
                q_hit = 1'b1;
`ifdef REGFILE_WSEQ_FWD_EN
                q_data = rf_wdata;
`endif
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (view_vld[k] && view_addr[k] == q_addr) begin
                    q_hit = 1'b1;
`ifdef REGFILE_WSEQ_FWD_EN
                    q_data = view_data[k];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Randomised bench for regfile_write_sequencer against a queue-based pending-write model.
`timescale 1ns/1ps
module tb_regfile_write_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] q_addr = '0;
    logic          q_hit;
`ifdef REGFILE_WSEQ_FWD_EN
    logic [DW-1:0] q_data;
`endif

    int total = 0;
    int bad = 0;

    // acc_*: accepted nonzero writes in acceptance order; obs_*: writes seen on the port.
    logic [AW-1:0] acc_a [$];
    logic [DW-1:0] acc_d [$];
    logic [AW-1:0] obs_a [$];
    logic [DW-1:0] obs_d [$];
    int n_done = 0;

    regfile_write_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .busy     (busy),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .q_addr   (q_addr),
`ifdef REGFILE_WSEQ_FWD_EN
        .q_data   (q_data),
`endif
        .q_hit    (q_hit)
    );

    always #5 clk = ~clk;

    // Entries seen on the port before this cycle have been committed to the register file.
    always @(negedge clk) begin
        n_done = obs_a.size();
        if (rf_we === 1'b1) begin
            obs_a.push_back(rf_addr);
            obs_d.push_back(rf_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

    task automatic clear_model();
        acc_a.delete(); acc_d.delete();
        obs_a.delete(); obs_d.delete();
        n_done = 0;
    endtask

    // Drive one cycle; return observed and model values of in_ready / q_hit / q_data.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] qa,
                        output logic [DW+1:0] got, output logic [DW+1:0] exp);
        logic rdy_e, hit_e;
        logic [DW-1:0] qd_e, qd_o;
        in_valid = v; in_addr = a; in_data = d; q_addr = qa;
        #1;
        rdy_e = (acc_a.size() - obs_a.size()) < DEPTH;
        hit_e = 1'b0;
        qd_e  = '0;
        for (int i = n_done; i < acc_a.size(); i++) begin
            if (qa != '0 && acc_a[i] == qa) begin
                hit_e = 1'b1;
                qd_e  = acc_d[i];
            end
        end
`ifdef REGFILE_WSEQ_FWD_EN
        qd_o = q_data;
`else
        qd_o = '0;
        qd_e = '0;
`endif
        got = {in_ready, q_hit, qd_o};
        exp = {rdy_e, hit_e, qd_e};
        if (v && rdy_e && a != '0) begin
            acc_a.push_back(a);
            acc_d.push_back(d);
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_clear(input string nm);
        int cnt, qbad, oerr;
        clear_model();
        q_addr = 5'd3;
        rst = 1'b1;
        cnt = 0; qbad = 0; oerr = 0;
        repeat (40) begin
            if (busy === 1'b1) cnt++;
            if (q_hit !== 1'b0) qbad++;
            @(negedge clk); #1;
        end
        total++;
        if (cnt !== NR) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, cnt, NR); end
        total++;
        if (qbad !== 0) begin bad++; $display("FAIL %s_qhit_in_clear got=%0d exp=0", nm, qbad); end
        if (obs_a.size() != NR) oerr++;
        else for (int i = 0; i < NR; i++) if (obs_a[i] !== AW'(i) || obs_d[i] !== '0) oerr++;
        total++;
        if (oerr !== 0) begin bad++; $display("FAIL %s_clear_writes got=%0d writes/%0d bad exp=%0d ordered zero writes", nm, obs_a.size(), oerr, NR); end
        total++;
        if ({busy, in_ready} !== 2'b01) begin bad++; $display("FAIL %s_run_entry got busy=%b rdy=%b exp busy=0 rdy=1", nm, busy, in_ready); end
        clear_model();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, in_ready, rf_we, rf_addr, rf_wdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_state got busy=%b rdy=%b we=%b addr=%0d data=%h exp 1 0 0 0 0",
                     busy, in_ready, rf_we, rf_addr, rf_wdata);
        end
        run_clear("reset");
    endtask

    task automatic test_single();
        logic [DW+1:0] g, e;
        step(1'b1, 5'd5, 32'h36, 5'd5, g, e);
        total++; if (g !== e) begin bad++; $display("FAIL single_push got=%h exp=%h", g, e); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_lat_n got we=%b exp 0", rf_we); end
        step(1'b0, 5'd0, 32'd0, 5'd5, g, e);
        total++; if (g !== e) begin bad++; $display("FAIL single_q1 got=%h exp=%h", g, e); end
        total++;
        if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 5'd5, 32'h36}) begin
            bad++; $display("FAIL single_write got we=%b addr=%0d data=%h exp 1 5 36", rf_we, rf_addr, rf_wdata);
        end
        step(1'b0, 5'd0, 32'd0, 5'd5, g, e);
        total++; if (g !== e) begin bad++; $display("FAIL single_q2 got=%h exp=%h", g, e); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got we=%b exp 0", rf_we); end
        step(1'b0, 5'd0, 32'd0, 5'd5, g, e);
        total++; if (g !== e) begin bad++; $display("FAIL single_q3 got=%h exp=%h", g, e); end
    endtask

    task automatic test_zero();
        logic [DW+1:0] g, e;
        int base;
        base = obs_a.size();
        step(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, g, e);
        total++; if (g !== e) begin bad++; $display("FAIL zero_push got=%h exp=%h", g, e); end
        repeat (3) begin
            step(1'b0, 5'd0, 32'd0, 5'd0, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL zero_query got=%h exp=%h", g, e); end
        end
        total++;
        if (obs_a.size() !== base) begin bad++; $display("FAIL zero_no_write got=%0d writes exp=%0d", obs_a.size(), base); end
    endtask

    task automatic test_back_to_back();
        logic [DW+1:0] g, e;
        int base, err;
        base = obs_a.size();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, AW'(i + 1), DW'(32'h10 + i), AW'(i + 1), g, e);
            total++; if (g !== e) begin bad++; $display("FAIL b2b_cycle%0d got=%h exp=%h", i, g, e); end
            total++; if (g[DW+1] !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, g[DW+1]); end
        end
        repeat (3) begin
            step(1'b0, 5'd0, 32'd0, 5'd3, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL b2b_drain got=%h exp=%h", g, e); end
        end
        err = 0;
        if (obs_a.size() != base + 6) err++;
        else for (int i = 0; i < 6; i++)
            if (obs_a[base+i] !== AW'(i + 1) || obs_d[base+i] !== DW'(32'h10 + i)) err++;
        total++;
        if (err !== 0) begin bad++; $display("FAIL b2b_order got=%0d new writes/%0d wrong exp=6 in order", obs_a.size() - base, err); end
    endtask

    task automatic test_fill();
        logic [DW+1:0] g, e;
        logic [DW-1:0] last9;
        bit seen9;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd9, DW'(32'hA + i), 5'd9, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL fill_push%0d got=%h exp=%h", i, g, e); end
        end
        repeat (5) begin
            step(1'b0, 5'd0, 32'd0, 5'd9, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL fill_query got=%h exp=%h", g, e); end
        end
        total++; if (q_hit !== 1'b0) begin bad++; $display("FAIL fill_hit_clear got=%b exp=0", q_hit); end
        seen9 = 0; last9 = '0;
        foreach (obs_a[i]) if (obs_a[i] == 5'd9) begin seen9 = 1; last9 = obs_d[i]; end
        total++;
        if ({seen9, last9} !== {1'b1, 32'hD}) begin bad++; $display("FAIL fill_final_r9 got=%h exp=d", last9); end
    endtask

    task automatic test_random();
        logic [DW+1:0] g, e;
        logic [DW-1:0] exp_rf [NR];
        logic [DW-1:0] got_rf [NR];
        int err;
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
                 AW'($urandom_range(0, 7)), g, e);
            total++; if (g !== e) begin bad++; $display("FAIL rand_cycle%0d got=%h exp=%h", c, g, e); end
        end
        repeat (4) begin
            step(1'b0, 5'd0, 32'd0, 5'd0, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL rand_drain got=%h exp=%h", g, e); end
        end
        err = 0;
        if (obs_a.size() != acc_a.size()) err++;
        else foreach (acc_a[i]) if (obs_a[i] !== acc_a[i] || obs_d[i] !== acc_d[i]) err++;
        total++;
        if (err !== 0) begin bad++; $display("FAIL rand_order got=%0d writes/%0d wrong exp=%0d", obs_a.size(), err, acc_a.size()); end
        for (int r = 0; r < NR; r++) begin exp_rf[r] = '0; got_rf[r] = '0; end
        foreach (acc_a[i]) exp_rf[acc_a[i]] = acc_d[i];
        foreach (obs_a[i]) got_rf[obs_a[i]] = obs_d[i];
        err = 0;
        for (int r = 0; r < NR; r++) if (got_rf[r] !== exp_rf[r]) err++;
        total++;
        if (err !== 0) begin bad++; $display("FAIL rand_regfile got=%0d registers differ exp=0", err); end
    endtask

    task automatic test_reset_mid();
        logic [DW+1:0] g, e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, AW'(11 + i), DW'(32'h100 + i), 5'd13, g, e);
            total++; if (g !== e) begin bad++; $display("FAIL mid_push%0d got=%h exp=%h", i, g, e); end
        end
        q_addr = 5'd13;
        rst = 1'b0;
        #1;
        total++;
        if ({busy, in_ready, rf_we, rf_addr, rf_wdata, q_hit} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset_outputs got busy=%b rdy=%b we=%b addr=%0d data=%h hit=%b exp 1 0 0 0 0 0",
                     busy, in_ready, rf_we, rf_addr, rf_wdata, q_hit);
        end
        repeat (2) @(negedge clk);
        #1;
        run_clear("mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_back_to_back();
        test_fill();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
